global_chain_bist: RTL and testbench
====================================

// Module: global_chain_bist
// PURPOSE
//   Parametrised logic-to-global routing test. A WIDTH-lane x DEPTH-stage register chain
//   shifts only when a logic-derived enable (a & b) is high. A built-in PRBS generator and
//   checker self-test the chain, and an error counter reports mismatches. Stage registers
//   are meant to be spread across the die by top-level placement constraints. This
//   stresses routing of a fabric-generated net to distant slices.
// PARAMETERS
//   WIDTH      4        chain lanes, 1..16
//   DEPTH      5        chain stages, >=1
//   NUM_CHECKS 16       enabled compare cycles per run, 1..65535
//   SEED       16'hACE1 LFSR start value, must be nonzero
// PORTS
//   clk       in  1      sole clock, rising edge
//   resetn    in  1      synchronous, active-low reset
//   a         in  1      enable term A
//   b         in  1      enable term B; en = a & b (combinational, no register)
//   start     in  1      begin self-test; sampled only in IDLE or DONE
//   inject    in  1      XOR into lane 0 of the stage-0 input (fault injection)
//   d         in  WIDTH  pass-through data, used in IDLE/DONE
//   q         out WIDTH  last chain stage
//   busy      out 1      high in FILL or CHECK
//   done      out 1      high in DONE
//   err_count out 16     mismatch count, saturating
// BEHAVIOUR
//   - Reset (resetn=0 at a clk edge): all stages 0, so q=0. gen=chk=SEED, err_count=0,
//     state=IDLE, busy=0, done=0. Reset wins over every other input, including mid-run.
//   - LFSR: 16-bit Fibonacci, taps 16,14,13,11. next = {s[14:0], s[15]^s[13]^s[12]^s[10]}.
//     Lane i of a pattern is s[i].
//   - Chain: on each clk edge with en=1, stage[k] <= stage[k-1] and
//     stage[0] <= src ^ {..,inject}. src = gen lanes in FILL/CHECK, d otherwise.
//     With en=0 the stages hold. Latency from input to q is DEPTH enabled cycles.
//   - FSM: IDLE, FILL, CHECK, DONE. Every state and counter advance requires en=1,
//     except start.
//     IDLE : start=1 -> FILL. Load gen=chk=SEED, err_count=0, cnt=0.
//     FILL : each en cycle, gen advances and cnt++. At cnt==DEPTH-1 -> CHECK, cnt=0.
//     CHECK: each en cycle, gen advances.
//            If q != chk lanes, err_count++ (saturate at 16'hFFFF).
//            chk advances, cnt++. At cnt==NUM_CHECKS-1 -> DONE.
//     DONE : hold err_count. start=1 -> FILL with the same reload as from IDLE.
//   - start is ignored in FILL and CHECK. Pulse length does not matter; level start in
//     DONE re-arms every cycle it is seen.
//   - Alignment: the first CHECK compare sees q = SEED lanes, because the stage-0 load
//     on the first FILL en cycle reaches q after DEPTH en cycles.
//   - Run time with en held at 1: DEPTH+NUM_CHECKS cycles from start to done.
//   - busy and done are registered, asserted the cycle after the state entry edge.
//   - No combinational path from inputs to q, busy, done or err_count.
// TESTING
//   1. W=4,D=5,N=16, a=b=1, start 1 cycle -> busy for 21 cycles, then done=1, err_count=0.
//   2. IDLE, a=b=1, d=4'hA held -> q=4'hA exactly 5 cycles after d applied; a=0 -> q frozen.
//   3. b toggling 1/0 each cycle, start -> done after 42 cycles, err_count=0.
//   4. inject=1 on the first FILL en cycle only -> err_count=1 at done.
//      inject held high through the run -> err_count=16.
//   5. resetn=0 for 1 cycle mid-CHECK -> next cycle state IDLE, q=0, err_count=0,
//      busy=0, done=0.
//   6. start pulsed during CHECK -> ignored, done at the nominal cycle.
//      start in DONE -> err_count clears and the run repeats with the same result.

Source files
------------

// File: rtl/global_chain_bist.sv
// global_chain_bist: WIDTH-lane x DEPTH-stage register chain gated by a
// fabric-derived enable (a & b), with a built-in PRBS generator/checker that
// self-tests the chain and a saturating mismatch counter.
module global_chain_bist #(
  parameter int          WIDTH      = 4,
  parameter int          DEPTH      = 5,
  parameter int          NUM_CHECKS = 16,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             a,
  input  logic             b,
  input  logic             start,
  input  logic             inject,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [15:0]      err_count
);

  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

  localparam logic [15:0] FILL_LAST  = 16'(DEPTH - 1);
  localparam logic [15:0] CHECK_LAST = 16'(NUM_CHECKS - 1);

  state_t           state_reg;
  logic [15:0]      gen_reg;
  logic [15:0]      chk_reg;
  logic [15:0]      cnt_reg;
  logic [15:0]      err_count_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] stage_reg [DEPTH];

  logic             en;
  logic [WIDTH-1:0] inj_mask;
  logic [WIDTH-1:0] stage_in;

  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // The enable is deliberately a plain fabric AND so it has to be routed to every stage
  assign en       = a & b;
  assign inj_mask = WIDTH'(inject);
  assign stage_in = (((state_reg == FILL) || (state_reg == CHECK)) ? gen_reg[WIDTH-1:0] : d)
                    ^ inj_mask;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        // Stage 0 takes the generator pattern during a test, pass-through data otherwise
        always_ff @(posedge clk) begin
          if (!resetn)  stage_reg[gi] <= '0;
          else if (en)  stage_reg[gi] <= stage_in;
        end
      end else begin : g_body
        // Each later stage shifts from its predecessor on enabled cycles
        always_ff @(posedge clk) begin
          if (!resetn)  stage_reg[gi] <= '0;
          else if (en)  stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = stage_reg[DEPTH-1];

  // Test sequencer: start reloads from IDLE/DONE; every other advance waits for en
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      gen_reg       <= SEED;
      chk_reg       <= SEED;
      cnt_reg       <= '0;
      err_count_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg     <= FILL;
            gen_reg       <= SEED;
            chk_reg       <= SEED;
            cnt_reg       <= '0;
            err_count_reg <= '0;
            busy_reg      <= 1'b1;
            done_reg      <= 1'b0;
          end
        end
        FILL: begin
          if (en) begin
            gen_reg <= lfsr_next(gen_reg);
            if (cnt_reg == FILL_LAST) begin
              state_reg <= CHECK;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end
        end
        CHECK: begin
          if (en) begin
            gen_reg <= lfsr_next(gen_reg);
            chk_reg <= lfsr_next(chk_reg);
            if ((q != chk_reg[WIDTH-1:0]) && (err_count_reg != 16'hFFFF))
              err_count_reg <= err_count_reg + 16'd1;
            if (cnt_reg == CHECK_LAST) begin
              state_reg <= DONE;
              cnt_reg   <= '0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_global_chain_bist.sv
// Directed bench for global_chain_bist (WIDTH=4, DEPTH=5, NUM_CHECKS=16).
module tb_global_chain_bist;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic             a, b, start, inject;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             busy, done;
  logic [15:0]      err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  global_chain_bist #(.WIDTH(4), .DEPTH(5), .NUM_CHECKS(16), .SEED(16'hACE1)) dut (
    .clk(clk), .resetn(resetn), .a(a), .b(b), .start(start), .inject(inject),
    .d(d), .q(q), .busy(busy), .done(done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // mode 0: no inject, 1: inject on first FILL en cycle, 2: inject held all run
  task automatic run_bist(input string tag, input int mode, input bit toggle_b,
                          input int pulse_cyc, input int exp_err, input int exp_cyc);
    int cyc;
    int e_err;
    int e_cyc;
    exp_q.push_back(exp_err);
    exp_q.push_back(exp_cyc);
    a = 1'b1; b = 1'b1; start = 1'b1;
    inject = (mode == 2);
    step();
    start = 1'b0;
    check({tag, "_reload_err"}, err_count, 0);
    check({tag, "_busy_on"}, busy, 1);
    check({tag, "_done_off"}, done, 0);
    cyc = 0;
    while (!done && cyc < 200) begin
      if (toggle_b) b = ~b;
      if (mode == 1) inject = (cyc == 0);
      start = (cyc == pulse_cyc);
      step();
      cyc++;
    end
    inject = 1'b0; start = 1'b0; b = 1'b1;
    e_err = exp_q.pop_front();
    e_cyc = exp_q.pop_front();
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_cycles"}, cyc, e_cyc);
    check({tag, "_err"}, err_count, e_err);
    check({tag, "_busy_off"}, busy, 0);
    $display("run %s: cycles=%0d err_count=%0d", tag, cyc, err_count);
  endtask

  initial begin
    resetn = 1'b0; a = 1'b0; b = 1'b0; start = 1'b0; inject = 1'b0; d = '0;
    step(); step();
    resetn = 1'b1;
    step();
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_count, 0);

    // Pass-through in IDLE: 4'hA reaches q after exactly 5 enabled edges
    a = 1'b1; b = 1'b1; d = 4'hA;
    for (int i = 0; i < 5; i++) exp_q.push_back((i == 4) ? 'hA : 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("pass_q%0d", i), q, exp_q.pop_front());
    end
    // Enable low: chain frozen even though d changes
    a = 1'b0; d = 4'h5;
    for (int i = 0; i < 3; i++) exp_q.push_back('hA);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold_q%0d", i), q, exp_q.pop_front());
    end
    a = 1'b1; d = '0;

    run_bist("basic", 0, 1'b0, -1, 0, 21);
    run_bist("toggle_b", 0, 1'b1, -1, 0, 42);
    run_bist("inject_once", 1, 1'b0, -1, 1, 21);
    run_bist("inject_held", 2, 1'b0, -1, 16, 21);
    run_bist("rerun_from_done", 2, 1'b0, -1, 16, 21);
    run_bist("start_in_check", 0, 1'b0, 8, 0, 21);

    // Reset in the middle of CHECK with errors accumulating
    a = 1'b1; b = 1'b1; inject = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("midrun_err_before_rst", err_count, 5);
    check("midrun_busy_before_rst", busy, 1);
    resetn = 1'b0;
    step();
    resetn = 1'b1; inject = 1'b0;
    check("midrun_rst_q", q, 0);
    check("midrun_rst_err", err_count, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_done", done, 0);
    // IDLE after reset: no start means nothing happens
    step();
    check("midrun_idle_busy", busy, 0);
    run_bist("after_reset", 0, 1'b0, -1, 0, 21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
